// File: rtl/tl_xbar_2to1.sv
// Two-master, one-slave TileLink-UL arbiter with one outstanding transaction; routes D beats back to the owner.
// Define TL_XBAR_RR_EN for round-robin arbitration; otherwise m1 (dl1) has fixed priority on a tie.
module tl_xbar_2to1 #(
    parameter int unsigned DW = 128,
    parameter int unsigned AW = 32,
    parameter int unsigned SW = 3,
    parameter int unsigned ZW = 8
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_a_valid,
    output logic            m0_a_ready,
    input  logic [2:0]      m0_a_opcode,
    input  logic [2:0]      m0_a_param,
    input  logic [ZW-1:0]   m0_a_size,
    input  logic [SW-1:0]   m0_a_source,
    input  logic [AW-1:0]   m0_a_address,
    input  logic [DW/8-1:0] m0_a_mask,
    input  logic [DW-1:0]   m0_a_data,
    input  logic            m0_a_corrupt,
    output logic            m0_d_valid,
    input  logic            m0_d_ready,
    output logic [2:0]      m0_d_opcode,
    output logic [1:0]      m0_d_param,
    output logic [ZW-1:0]   m0_d_size,
    output logic [SW-1:0]   m0_d_source,
    output logic [SW-1:0]   m0_d_sink,
    output logic            m0_d_denied,
    output logic [DW-1:0]   m0_d_data,
    output logic            m0_d_corrupt,

    input  logic            m1_a_valid,
    output logic            m1_a_ready,
    input  logic [2:0]      m1_a_opcode,
    input  logic [2:0]      m1_a_param,
    input  logic [ZW-1:0]   m1_a_size,
    input  logic [SW-1:0]   m1_a_source,
    input  logic [AW-1:0]   m1_a_address,
    input  logic [DW/8-1:0] m1_a_mask,
    input  logic [DW-1:0]   m1_a_data,
    input  logic            m1_a_corrupt,
    output logic            m1_d_valid,
    input  logic            m1_d_ready,
    output logic [2:0]      m1_d_opcode,
    output logic [1:0]      m1_d_param,
    output logic [ZW-1:0]   m1_d_size,
    output logic [SW-1:0]   m1_d_source,
    output logic [SW-1:0]   m1_d_sink,
    output logic            m1_d_denied,
    output logic [DW-1:0]   m1_d_data,
    output logic            m1_d_corrupt,

    output logic            s_a_valid,
    input  logic            s_a_ready,
    output logic [2:0]      s_a_opcode,
    output logic [2:0]      s_a_param,
    output logic [ZW-1:0]   s_a_size,
    output logic [SW-1:0]   s_a_source,
    output logic [AW-1:0]   s_a_address,
    output logic [DW/8-1:0] s_a_mask,
    output logic [DW-1:0]   s_a_data,
    output logic            s_a_corrupt,
    input  logic            s_d_valid,
    output logic            s_d_ready,
    input  logic [2:0]      s_d_opcode,
    input  logic [1:0]      s_d_param,
    input  logic [ZW-1:0]   s_d_size,
    input  logic [SW-1:0]   s_d_source,
    input  logic [SW-1:0]   s_d_sink,
    input  logic            s_d_denied,
    input  logic [DW-1:0]   s_d_data,
    input  logic            s_d_corrupt
);

    localparam logic [2:0] OP_GET = 3'd4;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [2:0] beats_q, beats_d;
`ifdef TL_XBAR_RR_EN
    logic       rr_ptr_q, rr_ptr_d;
`endif

    logic          in_req;
    logic          grant;
    logic          sel_a_valid;
    logic          sel_d_ready;
    logic [2:0]    sel_a_opcode;
    logic [ZW-1:0] sel_a_size;

    // Get response length in beats for a DW=128 (16-byte) data bus
    function automatic logic [2:0] get_beats(input logic [ZW-1:0] size);
        if (size <= ZW'(4))
            return 3'd1;
        else if (size == ZW'(5))
            return 3'd2;
        else
            return 3'd4;
    endfunction

    assign in_req       = (state_q == REQ);
    assign sel_a_valid  = owner_q ? m1_a_valid  : m0_a_valid;
    assign sel_a_opcode = owner_q ? m1_a_opcode : m0_a_opcode;
    assign sel_a_size   = owner_q ? m1_a_size   : m0_a_size;
    assign sel_d_ready  = owner_q ? m1_d_ready  : m0_d_ready;

    // A payload follows the owner only while a request is presented; zero otherwise
    assign s_a_opcode  = in_req ? sel_a_opcode : '0;
    assign s_a_param   = in_req ? (owner_q ? m1_a_param   : m0_a_param)   : '0;
    assign s_a_size    = in_req ? sel_a_size : '0;
    assign s_a_source  = in_req ? (owner_q ? m1_a_source  : m0_a_source)  : '0;
    assign s_a_address = in_req ? (owner_q ? m1_a_address : m0_a_address) : '0;
    assign s_a_mask    = in_req ? (owner_q ? m1_a_mask    : m0_a_mask)    : '0;
    assign s_a_data    = in_req ? (owner_q ? m1_a_data    : m0_a_data)    : '0;
    assign s_a_corrupt = in_req & (owner_q ? m1_a_corrupt : m0_a_corrupt);

    // D payload is broadcast; only d_valid distinguishes the owner
    assign m0_d_opcode  = s_d_opcode;
    assign m0_d_param   = s_d_param;
    assign m0_d_size    = s_d_size;
    assign m0_d_source  = s_d_source;
    assign m0_d_sink    = s_d_sink;
    assign m0_d_denied  = s_d_denied;
    assign m0_d_data    = s_d_data;
    assign m0_d_corrupt = s_d_corrupt;
    assign m1_d_opcode  = s_d_opcode;
    assign m1_d_param   = s_d_param;
    assign m1_d_size    = s_d_size;
    assign m1_d_source  = s_d_source;
    assign m1_d_sink    = s_d_sink;
    assign m1_d_denied  = s_d_denied;
    assign m1_d_data    = s_d_data;
    assign m1_d_corrupt = s_d_corrupt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            beats_q  <= 3'd0;
`ifdef TL_XBAR_RR_EN
            rr_ptr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            beats_q  <= beats_d;
`ifdef TL_XBAR_RR_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beats_d    = beats_q;
`ifdef TL_XBAR_RR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        grant      = m1_a_valid;
        s_a_valid  = 1'b0;
        s_d_ready  = 1'b0;
        m0_a_ready = 1'b0;
        m1_a_ready = 1'b0;
        m0_d_valid = 1'b0;
        m1_d_valid = 1'b0;

        // Tie-break: rr pointer, or dl1 by fixed priority
        if (m0_a_valid && m1_a_valid) begin
`ifdef TL_XBAR_RR_EN
            grant = rr_ptr_q;
`else
            grant = 1'b1;
`endif
        end

        case (state_q)
            IDLE: begin
                if (m0_a_valid || m1_a_valid) begin
                    owner_d  = grant;
`ifdef TL_XBAR_RR_EN
                    rr_ptr_d = ~grant;
`endif
                    state_d  = REQ;
                end
            end
            REQ: begin
                s_a_valid  = sel_a_valid;
                m0_a_ready = ~owner_q & s_a_ready;
                m1_a_ready = owner_q & s_a_ready;
                if (sel_a_valid && s_a_ready) begin
                    beats_d = (sel_a_opcode == OP_GET) ? get_beats(sel_a_size) : 3'd1;
                    state_d = RESP;
                end
            end
            RESP: begin
                m0_d_valid = ~owner_q & s_d_valid;
                m1_d_valid = owner_q & s_d_valid;
                s_d_ready  = sel_d_ready;
                if (s_d_valid && sel_d_ready) begin
                    beats_d = beats_q - 3'd1;
                    if (beats_q == 3'd1)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tl_xbar_2to1.sv
// Directed self-checking bench for tl_xbar_2to1; the bench plays both masters and the slave.
module tb_tl_xbar_2to1;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = 3;
    localparam int unsigned ZW = 8;

    logic clk, rst;

    logic m0_a_valid, m0_a_ready, m0_a_corrupt;
    logic [2:0] m0_a_opcode, m0_a_param;
    logic [ZW-1:0] m0_a_size;
    logic [SW-1:0] m0_a_source;
    logic [AW-1:0] m0_a_address;
    logic [DW/8-1:0] m0_a_mask;
    logic [DW-1:0] m0_a_data;
    logic m0_d_valid, m0_d_ready, m0_d_denied, m0_d_corrupt;
    logic [2:0] m0_d_opcode;
    logic [1:0] m0_d_param;
    logic [ZW-1:0] m0_d_size;
    logic [SW-1:0] m0_d_source, m0_d_sink;
    logic [DW-1:0] m0_d_data;

    logic m1_a_valid, m1_a_ready, m1_a_corrupt;
    logic [2:0] m1_a_opcode, m1_a_param;
    logic [ZW-1:0] m1_a_size;
    logic [SW-1:0] m1_a_source;
    logic [AW-1:0] m1_a_address;
    logic [DW/8-1:0] m1_a_mask;
    logic [DW-1:0] m1_a_data;
    logic m1_d_valid, m1_d_ready, m1_d_denied, m1_d_corrupt;
    logic [2:0] m1_d_opcode;
    logic [1:0] m1_d_param;
    logic [ZW-1:0] m1_d_size;
    logic [SW-1:0] m1_d_source, m1_d_sink;
    logic [DW-1:0] m1_d_data;

    logic s_a_valid, s_a_ready, s_a_corrupt;
    logic [2:0] s_a_opcode, s_a_param;
    logic [ZW-1:0] s_a_size;
    logic [SW-1:0] s_a_source;
    logic [AW-1:0] s_a_address;
    logic [DW/8-1:0] s_a_mask;
    logic [DW-1:0] s_a_data;
    logic s_d_valid, s_d_ready, s_d_denied, s_d_corrupt;
    logic [2:0] s_d_opcode;
    logic [1:0] s_d_param;
    logic [ZW-1:0] s_d_size;
    logic [SW-1:0] s_d_source, s_d_sink;
    logic [DW-1:0] s_d_data;

    int checks = 0;
    int errors = 0;

    tl_xbar_2to1 #(.DW(DW), .AW(AW), .SW(SW), .ZW(ZW)) dut (
        .clk(clk), .rst(rst),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
        .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
        .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
        .m0_a_corrupt(m0_a_corrupt), .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
        .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param), .m0_d_size(m0_d_size),
        .m0_d_source(m0_d_source), .m0_d_sink(m0_d_sink), .m0_d_denied(m0_d_denied),
        .m0_d_data(m0_d_data), .m0_d_corrupt(m0_d_corrupt),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
        .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
        .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
        .m1_a_corrupt(m1_a_corrupt), .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
        .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param), .m1_d_size(m1_d_size),
        .m1_d_source(m1_d_source), .m1_d_sink(m1_d_sink), .m1_d_denied(m1_d_denied),
        .m1_d_data(m1_d_data), .m1_d_corrupt(m1_d_corrupt),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
        .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
        .s_a_corrupt(s_a_corrupt), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
        .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
        .s_d_source(s_d_source), .s_d_sink(s_d_sink), .s_d_denied(s_d_denied),
        .s_d_data(s_d_data), .s_d_corrupt(s_d_corrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        m0_a_valid = 0; m0_a_opcode = 0; m0_a_param = 0; m0_a_size = 0; m0_a_source = 0;
        m0_a_address = 0; m0_a_mask = 0; m0_a_data = 0; m0_a_corrupt = 0; m0_d_ready = 0;
        m1_a_valid = 0; m1_a_opcode = 0; m1_a_param = 0; m1_a_size = 0; m1_a_source = 0;
        m1_a_address = 0; m1_a_mask = 0; m1_a_data = 0; m1_a_corrupt = 0; m1_d_ready = 0;
        s_a_ready = 0; s_d_valid = 0; s_d_opcode = 0; s_d_param = 0; s_d_size = 0;
        s_d_source = 0; s_d_sink = 0; s_d_denied = 0; s_d_data = 0; s_d_corrupt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_inputs();
        m0_a_valid = 1; m1_a_valid = 1; m0_a_address = 32'hDEADBEEF; m0_a_data = 128'hFF;
        s_a_ready = 1; s_d_valid = 1; m0_d_ready = 1; m1_d_ready = 1;
        cyc();
        checks++;
        if ({s_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_d_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000",
                     {s_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_d_ready});
        end
        checks++;
        if (s_a_address !== 32'h0) begin
            errors++; $display("FAIL reset_s_a_address got %h exp 0", s_a_address);
        end
        checks++;
        if (s_a_data !== 128'h0) begin
            errors++; $display("FAIL reset_s_a_data got %h exp 0", s_a_data);
        end
        clr_inputs();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_contention();
        logic win;
`ifdef TL_XBAR_RR_EN
        win = 1'b0;
`else
        win = 1'b1;
`endif
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_size = 0; m0_a_source = 3'd1; m0_a_address = 32'h1000;
        m1_a_valid = 1; m1_a_opcode = 3'd4; m1_a_size = 0; m1_a_source = 3'd5; m1_a_address = 32'h2000;
        m0_d_ready = 1; m1_d_ready = 1;
        #1;
        checks++;
        if (s_a_valid !== 1'b0) begin
            errors++; $display("FAIL cont_arb_cycle s_a_valid got %b exp 0", s_a_valid);
        end
        cyc();
        checks++;
        if (s_a_valid !== 1'b1 || s_a_source !== (win ? 3'd5 : 3'd1)) begin
            errors++; $display("FAIL cont_first_src got v=%b src=%0d exp v=1 src=%0d",
                               s_a_valid, s_a_source, win ? 5 : 1);
        end
        s_a_ready = 1;
        #1;
        checks++;
        if ({m1_a_ready, m0_a_ready} !== (win ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL cont_a_ready got %b exp %b", {m1_a_ready, m0_a_ready},
                               win ? 2'b10 : 2'b01);
        end
        cyc();
        if (win) m1_a_valid = 0; else m0_a_valid = 0;
        s_a_ready = 0; s_d_valid = 1; s_d_opcode = 3'd1; s_d_source = win ? 3'd5 : 3'd1;
        #1;
        checks++;
        if ({m1_d_valid, m0_d_valid} !== (win ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL cont_first_d got %b exp %b", {m1_d_valid, m0_d_valid},
                               win ? 2'b10 : 2'b01);
        end
        cyc();
        s_d_valid = 0;
        cyc();
        checks++;
        if (s_a_valid !== 1'b1 || s_a_source !== (win ? 3'd1 : 3'd5)) begin
            errors++; $display("FAIL cont_second_src got v=%b src=%0d exp v=1 src=%0d",
                               s_a_valid, s_a_source, win ? 1 : 5);
        end
        s_a_ready = 1;
        cyc();
        if (win) m0_a_valid = 0; else m1_a_valid = 0;
        s_a_ready = 0; s_d_valid = 1;
        #1;
        checks++;
        if ({m1_d_valid, m0_d_valid} !== (win ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL cont_second_d got %b exp %b", {m1_d_valid, m0_d_valid},
                               win ? 2'b01 : 2'b10);
        end
        cyc();
        clr_inputs();
        #1;
    endtask

    task automatic test_single_get();
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_size = 8'd4; m0_a_source = 3'd2;
        m0_a_address = 32'h8000_0000;
        #1;
        checks++;
        if (s_a_valid !== 1'b0) begin
            errors++; $display("FAIL get_grant_delay s_a_valid got %b exp 0", s_a_valid);
        end
        cyc();
        checks++;
        if (s_a_valid !== 1'b1 || s_a_address !== 32'h8000_0000 || s_a_size !== 8'd4) begin
            errors++; $display("FAIL get_s_a got v=%b addr=%h size=%0d exp v=1 addr=80000000 size=4",
                               s_a_valid, s_a_address, s_a_size);
        end
        s_a_ready = 1;
        #1;
        checks++;
        if (m0_a_ready !== 1'b1 || m1_a_ready !== 1'b0) begin
            errors++; $display("FAIL get_a_ready got m0=%b m1=%b exp m0=1 m1=0", m0_a_ready, m1_a_ready);
        end
        cyc();
        m0_a_valid = 0; s_a_ready = 0;
        s_d_valid = 1; s_d_opcode = 3'd1; s_d_source = 3'd2; s_d_data = 128'hA5A5_0000_1234_5678;
        m0_d_ready = 1; m1_d_ready = 0;
        #1;
        checks++;
        if (m0_d_valid !== 1'b1 || m0_d_opcode !== 3'd1 || m0_d_source !== 3'd2 ||
            m0_d_data !== 128'hA5A5_0000_1234_5678) begin
            errors++; $display("FAIL get_m0_d got v=%b op=%0d src=%0d data=%h", m0_d_valid,
                               m0_d_opcode, m0_d_source, m0_d_data);
        end
        checks++;
        if (m1_d_valid !== 1'b0 || s_d_ready !== 1'b1) begin
            errors++; $display("FAIL get_route got m1_d_valid=%b s_d_ready=%b exp 0 1",
                               m1_d_valid, s_d_ready);
        end
        cyc();
        checks++;
        if (m0_d_valid !== 1'b0 || s_d_ready !== 1'b0) begin
            errors++; $display("FAIL get_back_idle got m0_d_valid=%b s_d_ready=%b exp 0 0",
                               m0_d_valid, s_d_ready);
        end
        clr_inputs();
        #1;
    endtask

    task automatic test_burst();
        m1_a_valid = 1; m1_a_opcode = 3'd4; m1_a_size = 8'd6; m1_a_source = 3'd3; m1_a_address = 32'h40;
        s_a_ready = 1;
        cyc();
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_size = 8'd0; m0_a_source = 3'd6;
        #1;
        checks++;
        if (m1_a_ready !== 1'b1 || m0_a_ready !== 1'b0) begin
            errors++; $display("FAIL burst_a_ready got m1=%b m0=%b exp 1 0", m1_a_ready, m0_a_ready);
        end
        cyc();
        m1_a_valid = 0; s_a_ready = 0;
        s_d_valid = 1; s_d_opcode = 3'd1; m1_d_ready = 1; m0_d_ready = 1;
        for (int i = 0; i < 4; i++) begin
            s_d_data = 128'(i + 1);
            #1;
            checks++;
            if ({m1_d_valid, m0_d_valid, m0_a_ready} !== 3'b100 || m1_d_data !== 128'(i + 1)) begin
                errors++; $display("FAIL burst_beat%0d got m1v=%b m0v=%b m0rdy=%b data=%h exp 1 0 0 %0d",
                                   i, m1_d_valid, m0_d_valid, m0_a_ready, m1_d_data, i + 1);
            end
            cyc();
        end
        checks++;
        if ({m1_d_valid, s_d_ready, m0_a_ready, s_a_valid} !== 4'b0) begin
            errors++; $display("FAIL burst_end got m1v=%b sdr=%b m0rdy=%b sav=%b exp 0000",
                               m1_d_valid, s_d_ready, m0_a_ready, s_a_valid);
        end
        s_d_valid = 0;
        cyc();
        checks++;
        if (s_a_valid !== 1'b1 || s_a_source !== 3'd6) begin
            errors++; $display("FAIL burst_next_grant got v=%b src=%0d exp v=1 src=6", s_a_valid, s_a_source);
        end
        s_a_ready = 1;
        cyc();
        m0_a_valid = 0; s_a_ready = 0; s_d_valid = 1;
        cyc();
        clr_inputs();
        #1;
    endtask

    task automatic test_put();
        m1_a_valid = 1; m1_a_opcode = 3'd0; m1_a_size = 8'd3; m1_a_source = 3'd4;
        m1_a_address = 32'h100; m1_a_mask = 16'h00FF; m1_a_data = 128'h1122334455667788;
        cyc();
        checks++;
        if (s_a_mask !== 16'h00FF || s_a_data !== 128'h1122334455667788 || s_a_opcode !== 3'd0 ||
            s_a_source !== 3'd4) begin
            errors++; $display("FAIL put_s_a got mask=%h data=%h op=%0d src=%0d", s_a_mask, s_a_data,
                               s_a_opcode, s_a_source);
        end
        s_a_ready = 1;
        cyc();
        m1_a_valid = 0; s_a_ready = 0;
        s_d_valid = 1; s_d_opcode = 3'd0; s_d_source = 3'd4; m1_d_ready = 1;
        #1;
        checks++;
        if (m1_d_valid !== 1'b1 || m1_d_opcode !== 3'd0 || m1_d_source !== 3'd4 || m0_d_valid !== 1'b0) begin
            errors++; $display("FAIL put_ack got m1v=%b op=%0d src=%0d m0v=%b", m1_d_valid,
                               m1_d_opcode, m1_d_source, m0_d_valid);
        end
        cyc();
        checks++;
        if (s_d_ready !== 1'b0 || m1_d_valid !== 1'b0) begin
            errors++; $display("FAIL put_single_beat got sdr=%b m1v=%b exp 0 0", s_d_ready, m1_d_valid);
        end
        clr_inputs();
        #1;
    endtask

    task automatic test_backpressure();
        int beat;
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_size = 8'd5; m0_a_source = 3'd1;
        s_a_ready = 1;
        cyc();
        cyc();
        m0_a_valid = 0; s_a_ready = 0;
        s_d_valid = 1; s_d_opcode = 3'd1; m1_d_ready = 1;
        beat = 0;
        for (int i = 0; i < 4; i++) begin
            m0_d_ready = i[0];
            s_d_data = 128'(beat + 10);
            #1;
            checks++;
            if (s_d_ready !== m0_d_ready || m0_d_valid !== 1'b1 || m0_d_data !== 128'(beat + 10)) begin
                errors++; $display("FAIL bp_cycle%0d got sdr=%b m0v=%b data=%h exp sdr=%b m0v=1 data=%0d",
                                   i, s_d_ready, m0_d_valid, m0_d_data, m0_d_ready, beat + 10);
            end
            if (m0_d_ready) beat++;
            cyc();
        end
        m0_d_ready = 1;
        #1;
        checks++;
        if (s_d_ready !== 1'b0 || m0_d_valid !== 1'b0) begin
            errors++; $display("FAIL bp_done got sdr=%b m0v=%b exp 0 0", s_d_ready, m0_d_valid);
        end
        clr_inputs();
        #1;
    endtask

    task automatic test_reset_mid();
        m1_a_valid = 1; m1_a_opcode = 3'd4; m1_a_size = 8'd6; m1_a_source = 3'd2;
        s_a_ready = 1;
        cyc();
        cyc();
        m1_a_valid = 0; s_a_ready = 0; s_d_valid = 1; s_d_opcode = 3'd1; m1_d_ready = 1;
        cyc();
        checks++;
        if (m1_d_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_in_resp got m1v=%b exp 1", m1_d_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({s_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_d_ready} !== 6'b0) begin
            errors++; $display("FAIL rstmid_ctrl got %b exp 000000",
                               {s_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_d_ready});
        end
        cyc();
        clr_inputs();
        rst = 1'b0;
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_size = 8'd0; m0_a_source = 3'd7;
        #1;
        checks++;
        if (s_a_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle got s_a_valid=%b exp 0", s_a_valid);
        end
        cyc();
        s_a_ready = 1;
        #1;
        checks++;
        if (s_a_valid !== 1'b1 || m0_a_ready !== 1'b1 || s_a_source !== 3'd7) begin
            errors++; $display("FAIL rstmid_regrant got v=%b rdy=%b src=%0d exp 1 1 7",
                               s_a_valid, m0_a_ready, s_a_source);
        end
        cyc();
        m0_a_valid = 0; s_a_ready = 0; s_d_valid = 1; m0_d_ready = 1;
        cyc();
        clr_inputs();
        #1;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_get();
        test_burst();
        test_put();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_xbar_2to1.md
# tl_xbar_2to1

Two-master, one-slave TileLink-UL arbiter that lets the core's `il1` and `dl1` channels share a single `tl_mem` slave. It sits directly between the `Rift2Core` memory ports and the memory model. It serializes transactions with one outstanding request at a time, and routes each D-channel response, including multi-beat `AccessAckData` bursts, back to the master that issued the request.

## Interface
Parameters:
- `DW`, 128, A/D data width in bits; mask width is `DW/8`
- `AW`, 32, address width
- `SW`, 3, source and sink width
- `ZW`, 8, size field width

Ports (`mN` denotes `m0` = il1 and `m1` = dl1; each exists twice):
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mN_a_valid`  in  1  master A valid
- `mN_a_ready`  out  1  master A ready
- `mN_a_opcode`/`mN_a_param`  in  3/3  A opcode, param
- `mN_a_size`/`mN_a_source`/`mN_a_address`  in  ZW/SW/AW  A fields
- `mN_a_mask`/`mN_a_data`/`mN_a_corrupt`  in  DW/8/DW/1  A payload
- `mN_d_valid`  out  1  master D valid
- `mN_d_ready`  in  1  master D ready
- `mN_d_opcode`/`mN_d_param`/`mN_d_size`  out  3/2/ZW  D fields
- `mN_d_source`/`mN_d_sink`/`mN_d_denied`  out  SW/SW/1  D fields
- `mN_d_data`/`mN_d_corrupt`  out  DW/1  D payload
- `s_a_*`  out  mirror of the master A fields, plus `s_a_valid` out and `s_a_ready` in
- `s_d_*`  in  mirror of the master D fields, plus `s_d_valid` in and `s_d_ready` out

## Operation
- FSM states: `IDLE`, `REQ`, `RESP`. Registers: `owner` (1b), `rr_ptr` (1b), `beats` (3b).
- `IDLE`:
  - If no master asserts `a_valid`, stay in `IDLE`.
  - Otherwise grant one master: if only one is valid, grant it; if both are valid, grant `rr_ptr`.
  - Load `owner` with the granted master, set `rr_ptr <= ~granted`, go to `REQ`.
- `REQ`:
  - Drive `s_a_*` from `owner`'s A bundle; `s_a_valid = owner a_valid`.
  - `owner a_ready = s_a_ready`; the non-owner's `a_ready` is 0.
  - On A fire, load `beats` and go to `RESP`:
    - `opcode==4` (Get): `beats = (size<=4) ? 1 : 2^(size-4)`.
    - All other opcodes (PutFull=0, PutPartial=1): `beats = 1`.
  - Supported sizes are 0..6; sizes above 6 are undefined.
- `RESP`:
  - `s_d_*` payload goes to both masters.
  - `owner d_valid = s_d_valid`; the non-owner's `d_valid` is 0.
  - `s_d_ready = owner d_ready`.
  - Each D fire decrements `beats`; the fire with `beats==1` returns to `IDLE`.
- Source, sink and all other fields pass through unmodified. No ID remapping, because only one transaction is ever outstanding.
- Outside `RESP`, `s_d_ready` is 0. Outside `REQ`, `s_a_valid` is 0.
- The A channel is always single-beat. Multi-beat puts are not supported.

## Timing
- Reset values: state `IDLE`, `owner=0`, `rr_ptr=0`, `beats=0`. All `*_valid` and `*_ready` outputs are 0. `s_a_*` payload outputs are 0.
- Arbitration adds exactly one cycle: master `a_valid` rising at cycle N gives the earliest `s_a_valid` at N+1.
- After the last D beat fires at cycle M, the next grant happens at M+1 and the next `s_a_valid` at M+2.
- The D path is combinational slave→master with zero added latency, and so is ready master→slave.
- Masters must hold `a_valid` and A fields stable until fire. If `a_valid` drops in `REQ`, the block waits in `REQ`; it does not re-arbitrate.
- A request arriving while the arbiter is busy waits; its `a_ready` stays 0 until it is granted.
- Backpressure: `d_ready` low holds `beats` and the state unchanged.
- Asserting `rst` mid-transaction returns the block to reset values immediately. In-flight beats are dropped, and the slave must be reset with it.

## Configuration
- `TL_XBAR_RR_EN` defined:
  - Round-robin arbitration as described above.
  - `rr_ptr` toggles to the loser after each grant.
- Not defined:
  - Fixed priority: `m1` (dl1) always wins a simultaneous request.
  - The `rr_ptr` register is not implemented.

## Test plan
- Single Get: `m0` Get, `size=4`, `addr=0x80000000` → 1-cycle grant delay, one D beat to `m0` with `opcode=1`, `m1_d_valid` stays 0, FSM back to `IDLE`.
- Burst: `m1` Get, `size=6` → exactly 4 D beats to `m1`; `m0_a_ready` stays 0 throughout; return to `IDLE` after the 4th fire.
- Contention, RR on, both Gets asserted in the same cycle after reset → `m0` served first, then `m1`. With RR off → `m1` first.
- Put: `m1` PutFull, `size=3`, `mask=0x00FF`, `data=0x1122334455667788` → one AccessAck (`opcode=0`) to `m1`, mask and data observed unchanged on `s_a_*`.
- Backpressure: `m0` burst `size=5` with `m0_d_ready` toggling every cycle → `s_d_ready` mirrors it, exactly 2 beats delivered, no beat lost.
- Reset mid-`RESP` after 1 of 4 beats → all valids 0 and state `IDLE` in the same cycle; a new request is granted after `rst` deasserts.
